// File: rtl/inputbuf_rd_pkg.sv
// rtl/inputbuf_rd_pkg.sv - shared constants, FSM states and frame-length helper
// Purpose: frame lengths for the two writer modes, read FSM encoding.
// Ports: none (package).
package inputbuf_rd_pkg;

  localparam int unsigned FRAME_LEN_M1 = 3;
  localparam int unsigned FRAME_LEN_M0 = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // mode=1 selects the 3-word (mod-3) frame, mode=0 the 4-word frame
  function automatic int unsigned frame_len(input logic mode);
    return mode ? FRAME_LEN_M1 : FRAME_LEN_M0;
  endfunction

endpackage

// File: rtl/inputbuf_rd_if.sv
// rtl/inputbuf_rd_if.sv - write/commit inputs and framed output stream bundle
// Purpose: groups the writer-side and consumer-side signals of inputbuf_rd.
// Ports (signals): mode, wr_en, wr_addr, wr_data, wr_commit, out_ready (to buffer);
//                  out_data, out_valid, out_last, bank_full, ovf (from buffer).
interface inputbuf_rd_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_BITS = 2
);
  logic                 mode;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [DATA_W-1:0]    wr_data;
  logic                 wr_commit;
  logic [DATA_W-1:0]    out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [1:0]           bank_full;
  logic                 ovf;

  modport master (
    output mode, wr_en, wr_addr, wr_data, wr_commit, out_ready,
    input  out_data, out_valid, out_last, bank_full, ovf
  );

  modport slave (
    input  mode, wr_en, wr_addr, wr_data, wr_commit, out_ready,
    output out_data, out_valid, out_last, bank_full, ovf
  );
endinterface

// File: rtl/inputbuf_rd_ctr.sv
// rtl/inputbuf_rd_ctr.sv - read-index counter with terminal-count flag
// Purpose: word index within the frame being streamed.
// Ports: clk, r (sync reset), clear (restart at 0), en (advance),
//        len (frame length), q (index), tc (q == len-1).
module inputbuf_rd_ctr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         r,
  input  logic         clear,
  input  logic         en,
  input  logic [W:0]   len,
  output logic [W-1:0] q,
  output logic         tc
);

  localparam logic [W:0] ONE = (W+1)'(1);

  always_ff @(posedge clk) begin
    if (r || clear) begin
      q <= '0;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

  assign tc = ({1'b0, q} == (len - ONE));

endmodule

// File: rtl/inputbuf_rd.sv
// rtl/inputbuf_rd.sv - ping-pong frame buffer read side with valid/ready output
// Purpose: two banks filled by the mod-3/mod-4 writer, each committed frame
//          streamed out serially with a last-word flag.
// Ports: clk, r (sync active-high reset), bus (inputbuf_rd_if.slave):
//        mode, wr_en/wr_addr/wr_data, wr_commit, out_data/out_valid/out_ready/
//        out_last, bank_full, ovf.
import inputbuf_rd_pkg::*;

module inputbuf_rd #(
  parameter int DATA_W    = 16,
  parameter int ADDR_BITS = 2
) (
  input  logic          clk,
  input  logic          r,
  inputbuf_rd_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int LW    = ADDR_BITS + 1;

  state_t state, state_nx;

  logic                  wr_bank;
  logic                  rd_bank;
  logic [1:0]            bank_full;
  logic [1:0]            bank_full_nx;
  logic                  ovf_q;
  logic                  mode_q;
  logic [DATA_W-1:0]     mem [2][DEPTH];

  logic [ADDR_BITS-1:0]  rd_cnt;
  logic                  tc;
  logic [LW-1:0]         len;

  logic valid;
  logic fire;
  logic last_fire;
  logic start;
  logic restart;
  logic commit_ok;

  assign len       = LW'(frame_len(mode_q));
  assign commit_ok = bus.wr_commit && !bank_full[wr_bank];

  inputbuf_rd_ctr #(.W(ADDR_BITS)) u_ctr (
    .clk   (clk),
    .r     (r),
    .clear (start || last_fire),
    .en    (fire && !tc),
    .len   (len),
    .q     (rd_cnt),
    .tc    (tc)
  );

  always_comb begin
    state_nx  = state;
    valid     = 1'b0;
    fire      = 1'b0;
    last_fire = 1'b0;
    start     = 1'b0;
    restart   = 1'b0;
    case (state)
      IDLE: begin
        if (bank_full[rd_bank]) begin
          start    = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        valid     = 1'b1;
        fire      = bus.out_ready;
        last_fire = bus.out_ready && tc;
        if (last_fire) begin
          // other bank already waiting: restart in place, no idle bubble
          if (bank_full[~rd_bank]) begin
            restart = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // set and clear never hit the same bank: a commit needs an empty bank,
  // a final read needs a full one
  always_comb begin
    bank_full_nx = bank_full;
    if (commit_ok) bank_full_nx[wr_bank] = 1'b1;
    if (last_fire) bank_full_nx[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state     <= IDLE;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      bank_full <= 2'b00;
      ovf_q     <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      bank_full <= bank_full_nx;
      ovf_q     <= bus.wr_commit && bank_full[wr_bank];
      if (commit_ok) wr_bank <= ~wr_bank;
      if (last_fire) rd_bank <= ~rd_bank;
      if (start || restart) mode_q <= bus.mode;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && !bank_full[wr_bank]) begin
      mem[wr_bank][bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.out_valid = valid;
  assign bus.out_data  = valid ? mem[rd_bank][rd_cnt] : '0;
  assign bus.out_last  = valid && tc;
  assign bus.bank_full = bank_full;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_inputbuf_rd.sv
// tb/tb_inputbuf_rd.sv - scoreboard bench for inputbuf_rd
module tb_inputbuf_rd;

  logic clk;
  logic r;

  inputbuf_rd_if #(.DATA_W(16), .ADDR_BITS(2)) bus ();

  inputbuf_rd #(.DATA_W(16), .ADDR_BITS(2)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every accepted beat, checks hold under back-pressure
  logic        prev_v = 1'b0;
  logic        prev_rdy = 1'b0;
  logic        prev_r = 1'b1;
  logic [15:0] prev_d = '0;
  logic        prev_l = 1'b0;

  always @(negedge clk) begin
    logic [16:0] e;
    if (prev_v && !prev_rdy && !prev_r && !r) begin
      chk("hold_valid", 32'(bus.out_valid), 32'(1));
      chk("hold_data", 32'(bus.out_data), 32'(prev_d));
      chk("hold_last", 32'(bus.out_last), 32'(prev_l));
    end
    if (!r && !bus.out_valid) begin
      chk("idle_data_zero", 32'({bus.out_data, bus.out_last}), 32'(0));
    end
    if (!r && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_beat", 32'({bus.out_last, bus.out_data}), 32'h1ffff);
      end else begin
        e = expq.pop_front();
        chk("beat_data", 32'(bus.out_data), 32'(e[15:0]));
        chk("beat_last", 32'(bus.out_last), 32'(e[16]));
      end
    end
    prev_v   = bus.out_valid;
    prev_rdy = bus.out_ready;
    prev_r   = r;
    prev_d   = bus.out_data;
    prev_l   = bus.out_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic commit();
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b0;
  endtask

  // writes n words base+i at addresses 0..n-1; optionally queues the expected frame
  task automatic frame(input logic [15:0] base, input int n, input bit push);
    for (int i = 0; i < n; i++) begin
      wr(2'(i), base + 16'(i));
      if (push) expq.push_back({(i == n - 1), base + 16'(i)});
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick();
      k++;
    end
    if (!bus.out_valid) chk({name, "_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic drain(input string name, input bit toggle);
    int k;
    k = 0;
    while (!(expq.size() == 0 && !bus.out_valid) && k < 200) begin
      if (toggle) bus.out_ready = ~bus.out_ready;
      tick();
      k++;
    end
    chk({name, "_drained"}, 32'(expq.size()), 32'(0));
  endtask

  initial begin
    r             = 1'b1;
    bus.mode      = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_commit = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_last", 32'(bus.out_last), 32'(0));
    chk("rst_full", 32'(bus.bank_full), 32'(0));
    chk("rst_ovf", 32'(bus.ovf), 32'(0));
    r = 1'b0;
    tick();

    // basic mode 0, with commit-to-valid latency
    bus.out_ready = 1'b1;
    frame(16'hA000, 4, 1'b1);
    chk("t1_full_pre", 32'(bus.bank_full), 32'(0));
    commit();
    chk("t1_full_set", 32'(bus.bank_full), 32'(1));
    chk("t1_ovf", 32'(bus.ovf), 32'(0));
    chk("t1_lat_idle", 32'(bus.out_valid), 32'(0));
    tick();
    chk("t1_lat_send", 32'(bus.out_valid), 32'(1));
    drain("t1", 1'b0);
    chk("t1_full_clr", 32'(bus.bank_full), 32'(0));

    // mode 1 into bank 1 with back-pressure; word at addr 3 must not appear
    bus.mode = 1'b1;
    frame(16'hB000, 3, 1'b1);
    wr(2'd3, 16'hDEAD);
    commit();
    chk("t2_full", 32'(bus.bank_full), 32'(2));
    drain("t2", 1'b1);

    // ping-pong: both banks full before draining, 8 continuous beats
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    frame(16'hC000, 4, 1'b1);
    commit();
    frame(16'hC100, 4, 1'b1);
    commit();
    chk("t3_full", 32'(bus.bank_full), 32'(3));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_no_bubble", 32'(bus.out_valid), 32'(1));
      tick();
    end
    chk("t3_idle_after", 32'(bus.out_valid), 32'(0));
    drain("t3", 1'b0);

    // overflow: third commit with both banks full; ignored write into full bank
    bus.out_ready = 1'b0;
    frame(16'hD000, 4, 1'b1);
    commit();
    frame(16'hD100, 4, 1'b1);
    commit();
    wr(2'd0, 16'hBAD0);
    chk("t4_no_ovf_yet", 32'(bus.ovf), 32'(0));
    commit();
    chk("t4_ovf_pulse", 32'(bus.ovf), 32'(1));
    chk("t4_full_kept", 32'(bus.bank_full), 32'(3));
    tick();
    chk("t4_ovf_single", 32'(bus.ovf), 32'(0));
    bus.out_ready = 1'b1;
    drain("t4", 1'b0);

    // mode flips to 1 after beat 2: current frame still 4 beats, next one 3
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    frame(16'hE000, 4, 1'b1);
    commit();
    wait_valid("t5");
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.mode = 1'b1;
    drain("t5a", 1'b0);
    frame(16'hE100, 3, 1'b1);
    commit();
    drain("t5b", 1'b0);

    // reset during beat 2 abandons the frame
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;
    frame(16'hF000, 4, 1'b1);
    commit();
    wait_valid("t6");
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    r = 1'b1;
    tick();
    chk("t6_valid", 32'(bus.out_valid), 32'(0));
    chk("t6_full", 32'(bus.bank_full), 32'(0));
    chk("t6_ovf", 32'(bus.ovf), 32'(0));
    r = 1'b0;
    expq.delete();
    tick();
    bus.out_ready = 1'b1;
    frame(16'h5A00, 4, 1'b1);
    commit();
    chk("t6_new_full", 32'(bus.bank_full), 32'(1));
    drain("t6", 1'b0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
